register_dump: RTL and testbench

Snapshot-and-stream reader for a bank of `COUNT` `WIDTH`-bit CPU registers. It is the read-side counterpart to the register write/increment path: on `start` it freezes every register value in one edge. It then emits the registers selected by a mask, one word per valid/ready handshake, in ascending index order. It sits between the register bank and the debug/trace port, so register contents can be dumped while the core keeps running.

---
 rtl/register_dump.sv | 191 +++++++++++++++++++
 tb/tb_register_dump.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_dump.sv
// register_dump
// -----------------------------------------------------------------------------
// Snapshot-and-stream reader for a bank of COUNT registers, each WIDTH bits.
// When `start` is seen in IDLE, the block copies the whole register bank into a
// private snapshot in one edge. It then streams the registers chosen by `mask`
// in ascending index order, one word per valid/ready handshake. Because the
// dump reads only the snapshot, the core can keep writing its registers while
// the dump runs.
//
// Ports
//   capture    : clock; all state changes on its rising edge
//   reset      : synchronous, active-high reset
//   start      : request a dump (sampled only in IDLE)
//   mask       : register select, bit i selects register i (sampled with start)
//   values     : flattened register bank, register i = values[i*WIDTH +: WIDTH]
//   busy       : high whenever the controller is not IDLE
//   out_valid  : out_data/out_index/out_last carry a word
//   out_ready  : downstream takes the word on this edge when out_valid is high
//   out_data   : snapshot value of the current register
//   out_index  : index of the current register
//   out_last   : current word is the highest selected register
//   done       : one-cycle pulse after the dump completes
// -----------------------------------------------------------------------------
module register_dump #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  parameter int IDX_W = $clog2(COUNT)
) (
  input  logic                   capture,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT-1:0]       mask,
  input  logic [WIDTH*COUNT-1:0] values,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_last,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [COUNT-1:0] pend_reg,  pend_next;
  logic [IDX_W-1:0] idx_reg,   idx_next;
  logic [WIDTH-1:0] data_reg,  data_next;
  logic             last_reg,  last_next;
  logic             busy_reg,  busy_next;
  logic             valid_reg, valid_next;
  logic             done_reg,  done_next;

  logic [WIDTH-1:0] values_arr [COUNT];
  logic [WIDTH-1:0] snap_reg   [COUNT];

  logic             accept_start;
  logic [IDX_W-1:0] first_idx;
  logic [COUNT-1:0] first_rest;
  logic [COUNT-1:0] rem_mask;
  logic [IDX_W-1:0] next_idx;
  logic [COUNT-1:0] next_rest;

  // Lowest set bit of m. Callers guarantee that m is non-zero whenever the
  // result is used.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [COUNT-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = COUNT - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    return COUNT'(1) << idx;
  endfunction

  assign accept_start = (state_reg == IDLE) && start;

  // Index selection for the first word, taken straight from the live mask.
  assign first_idx  = lowest_set(mask);
  assign first_rest = mask & ~onehot(first_idx);

  // Index selection after the current word transfers: drop the current bit
  // and jump to the next set bit. Unselected indices cost no cycles.
  assign rem_mask  = pend_reg & ~onehot(idx_reg);
  assign next_idx  = lowest_set(rem_mask);
  assign next_rest = rem_mask & ~onehot(next_idx);

  // Unpack the bank and keep the snapshot, one register slice per element.
  // The snapshot is written only at the start-accept edge.
  generate
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_snap
      assign values_arr[gi] = values[gi*WIDTH +: WIDTH];

      always_ff @(posedge capture) begin
        if (reset) begin
          snap_reg[gi] <= '0;
        end else if (accept_start) begin
          snap_reg[gi] <= values_arr[gi];
        end
      end
    end
  endgenerate

  // Next-state and next-output logic. All outputs are registered from these
  // *_next values, so out_ready never reaches an output combinationally.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    last_next  = last_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          pend_next = mask;
          if (mask != '0) begin
            state_next = SEND;
            idx_next   = first_idx;
            // The snapshot is loaded on this same edge, so read the first
            // word directly from the live bank.
            data_next  = values_arr[first_idx];
            last_next  = (first_rest == '0);
          end else begin
            state_next = DONE;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_reg) begin
            state_next = DONE;
            pend_next  = '0;
          end else begin
            pend_next = rem_mask;
            idx_next  = next_idx;
            data_next = snap_reg[next_idx];
            last_next = (next_rest == '0);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next  = (state_next != IDLE);
    valid_next = (state_next == SEND);
    done_next  = (state_next == DONE);
  end

  always_ff @(posedge capture) begin
    if (reset) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  assign busy      = busy_reg;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_index = idx_reg;
  assign out_last  = last_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_register_dump.sv
// tb_register_dump
// -----------------------------------------------------------------------------
// Directed self-checking bench for register_dump (WIDTH=16, COUNT=4).
// Inputs change just after a falling edge, and outputs are sampled at the
// falling edge, half a cycle away from the rising edge where the DUT acts.
// Each scenario task does its own inline comparisons and prints one line per
// transaction it observes.
// -----------------------------------------------------------------------------
module tb_register_dump;

  localparam int WIDTH = 16;
  localparam int COUNT = 4;
  localparam int IDX_W = 2;

  logic                   capture;
  logic                   reset;
  logic                   start;
  logic [COUNT-1:0]       mask;
  logic [WIDTH*COUNT-1:0] values;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [IDX_W-1:0]       out_index;
  logic                   out_last;
  logic                   done;

  int tests;
  int fails;

  register_dump #(
    .WIDTH(WIDTH),
    .COUNT(COUNT),
    .IDX_W(IDX_W)
  ) dut (
    .capture  (capture),
    .reset    (reset),
    .start    (start),
    .mask     (mask),
    .values   (values),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .done     (done)
  );

  initial capture = 1'b0;
  always #5 capture = ~capture;

  // Bank used by most scenarios; register i lives in values[i*16 +: 16].
  localparam logic [63:0] BANK = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  // Drive start for exactly one rising edge. On return we are at the falling
  // edge just after the accept edge k, i.e. inside cycle k+1.
  task automatic pulse_start(input logic [COUNT-1:0] m);
    start = 1'b1;
    mask  = m;
    @(negedge capture);
    start = 1'b0;
    mask  = '0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    start     = 1'b0;
    mask      = '0;
    values    = BANK;
    out_ready = 1'b1;
    repeat (2) @(negedge capture);
    reset = 1'b0;
    tests++;
    if ({busy, out_valid, out_data, out_index, out_last, done} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b valid=%b data=%h idx=%0d last=%b done=%b, required all 0",
               busy, out_valid, out_data, out_index, out_last, done);
    end
    $display("[TB] reset: busy=%b valid=%b done=%b", busy, out_valid, done);
  endtask

  task automatic test_full_dump;
    logic [15:0] exp_data;
    out_ready = 1'b1;
    values    = BANK;
    pulse_start(4'b1111);
    for (int i = 0; i < 4; i++) begin
      exp_data = 16'h1111 * 16'(i + 1);
      $display("[TB] full word: valid=%b data=%h idx=%0d last=%b", out_valid, out_data, out_index, out_last);
      tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_data ||
          out_index !== IDX_W'(i) || out_last !== (i == 3) || done !== 1'b0) begin
        fails++;
        $display("FAIL full_word%0d: valid=%b busy=%b data=%h idx=%0d last=%b done=%b, required 1 1 %h %0d %b 0",
                 i, out_valid, busy, out_data, out_index, out_last, done, exp_data, i, (i == 3));
      end
      @(negedge capture);
    end
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_done: done=%b valid=%b busy=%b, required 1 0 1", done, out_valid, busy);
    end
    @(negedge capture);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_idle: done=%b busy=%b, required 0 0", done, busy);
    end
    $display("[TB] full dump complete: busy=%b", busy);
  endtask

  task automatic test_sparse;
    out_ready = 1'b1;
    values    = BANK;
    pulse_start(4'b1010);
    $display("[TB] sparse word: valid=%b data=%h idx=%0d last=%b", out_valid, out_data, out_index, out_last);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_index !== 2'd1 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL sparse_word0: valid=%b data=%h idx=%0d last=%b, required 1 2222 1 0",
               out_valid, out_data, out_index, out_last);
    end
    @(negedge capture);
    $display("[TB] sparse word: valid=%b data=%h idx=%0d last=%b", out_valid, out_data, out_index, out_last);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h4444 || out_index !== 2'd3 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL sparse_word1: valid=%b data=%h idx=%0d last=%b, required 1 4444 3 1",
               out_valid, out_data, out_index, out_last);
    end
    @(negedge capture);
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sparse_done: done=%b valid=%b, required 1 0", done, out_valid);
    end
    @(negedge capture);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    values    = BANK;
    pulse_start(4'b0011);
    // Change the live register 0 after the snapshot was taken.
    values[15:0] = 16'hBEEF;
    for (int s = 0; s < 3; s++) begin
      $display("[TB] stall %0d: valid=%b data=%h idx=%0d", s, out_valid, out_data, out_index);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_index !== 2'd0 || out_last !== 1'b0) begin
        fails++;
        $display("FAIL stall%0d: valid=%b data=%h idx=%0d last=%b, required 1 1111 0 0",
                 s, out_valid, out_data, out_index, out_last);
      end
      @(negedge capture);
    end
    out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_index !== 2'd0) begin
      fails++;
      $display("FAIL bp_word0: valid=%b data=%h idx=%0d, required 1 1111 0", out_valid, out_data, out_index);
    end
    @(negedge capture);
    $display("[TB] bp word: valid=%b data=%h idx=%0d last=%b", out_valid, out_data, out_index, out_last);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_index !== 2'd1 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL bp_word1: valid=%b data=%h idx=%0d last=%b, required 1 2222 1 1",
               out_valid, out_data, out_index, out_last);
    end
    @(negedge capture);
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: done=%b valid=%b, required 1 0", done, out_valid);
    end
    @(negedge capture);
    values = BANK;
  endtask

  task automatic test_empty_mask;
    out_ready = 1'b1;
    pulse_start(4'b0000);
    $display("[TB] empty: valid=%b done=%b busy=%b", out_valid, done, busy);
    tests++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL empty_done: valid=%b done=%b busy=%b, required 0 1 1", out_valid, done, busy);
    end
    @(negedge capture);
    tests++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_idle: valid=%b done=%b busy=%b, required 0 0 0", out_valid, done, busy);
    end
  endtask

  task automatic test_ignored_start;
    int words;
    int dones;
    words     = 0;
    dones     = 0;
    out_ready = 1'b1;
    values    = BANK;
    pulse_start(4'b1111);
    for (int c = 0; c < 10; c++) begin
      // Re-request a dump while the first one is still streaming.
      if (c == 1) begin
        start = 1'b1;
        mask  = 4'b0001;
      end else begin
        start = 1'b0;
        mask  = '0;
      end
      if (out_valid) words++;
      if (done) dones++;
      @(negedge capture);
    end
    start = 1'b0;
    $display("[TB] ignored start: words=%0d dones=%0d", words, dones);
    tests++;
    if (words !== 4 || dones !== 1) begin
      fails++;
      $display("FAIL ignored_start: words=%0d dones=%0d, required 4 1", words, dones);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    values    = BANK;
    pulse_start(4'b1111);
    @(negedge capture);
    tests++;
    if (out_index !== 2'd1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_index: idx=%0d valid=%b, required 1 1", out_index, out_valid);
    end
    reset = 1'b1;
    @(negedge capture);
    reset = 1'b0;
    $display("[TB] mid reset: busy=%b valid=%b data=%h idx=%0d", busy, out_valid, out_data, out_index);
    tests++;
    if ({busy, out_valid, out_data, out_index, out_last, done} !== '0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b valid=%b data=%h idx=%0d last=%b done=%b, required all 0",
               busy, out_valid, out_data, out_index, out_last, done);
    end
    pulse_start(4'b0100);
    $display("[TB] post-reset word: valid=%b data=%h idx=%0d last=%b", out_valid, out_data, out_index, out_last);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_index !== 2'd2 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_word: valid=%b data=%h idx=%0d last=%b, required 1 3333 2 1",
               out_valid, out_data, out_index, out_last);
    end
    @(negedge capture);
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_done: done=%b valid=%b, required 1 0", done, out_valid);
    end
    @(negedge capture);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    @(negedge capture);
    test_reset;
    test_full_dump;
    test_sparse;
    test_backpressure;
    test_empty_mask;
    test_ignored_start;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
